// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit-address / 32-bit-data single-master bus.
// Holds the default bus widths, the read/write encoding of M_wr and the
// DMA master state encoding.
package bus_pkg;

  localparam int BUS_ADDR_W = 8;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_LEN_W  = 8;

  // M_wr encoding
  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_FIN  = 3'd5
  } dma_state_e;

endpackage

// File: rtl/bus_dma_master.sv
// Block-copy bus master: reads one word at src, writes it to dst, repeated
// `length` times with ascending, wrapping addresses; 3 cycles per word at
// full grant, a grant-low cycle in RD or WR simply holds the bus cycle.
// Ports: clk/reset; start, src_addr, dst_addr, length (config, sampled on an
//   accepted start); busy, done (status); M_req, M_wr, M_addr, M_dout,
//   M_grant, M_din (bus master side).
// Optional: DMA_CHECKSUM_EN adds output `checksum`, the mod-2^DATA_W sum of
//   every word read during the last transfer.
// All outputs come straight from flops; nothing combinational reaches them
// from M_grant or M_din.
module bus_dma_master
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int LEN_W  = BUS_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef DMA_CHECKSUM_EN
  logic [DATA_W-1:0] ck_q, ck_d;
`endif

  // Outputs are computed for the *next* state so that they are already
  // valid during the cycle the state is entered.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
`ifdef DMA_CHECKSUM_EN
    ck_d    = ck_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef DMA_CHECKSUM_EN
          ck_d = '0;
`endif
          if (length != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = length;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end else begin
            // Empty copy: acknowledge without touching the bus.
            done_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (M_grant) begin
          state_d = ST_RD;
          addr_d  = src_q;
          wr_d    = BUS_RD;
        end
      end
      ST_RD: begin
        if (M_grant) begin
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        // Read data belongs to the granted RD cycle; grant is irrelevant here.
        buf_d   = M_din;
`ifdef DMA_CHECKSUM_EN
        ck_d    = ck_q + M_din;
`endif
        state_d = ST_WR;
        addr_d  = dst_q;
        wr_d    = BUS_WR;
      end
      ST_WR: begin
        if (M_grant) begin
          src_d = src_q + ADDR_W'(1);
          dst_d = dst_q + ADDR_W'(1);
          rem_d = rem_q - LEN_W'(1);
          wr_d  = BUS_RD;
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_FIN;
            req_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD;
            addr_d  = src_q + ADDR_W'(1);
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        wr_d    = BUS_RD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= BUS_RD;
      addr_q  <= '0;
`ifdef DMA_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
`ifdef DMA_CHECKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign M_req  = req_q;
  assign M_wr   = wr_q;
  assign M_addr = addr_q;
  // The capture buffer is the write-data register.
  assign M_dout = buf_q;
`ifdef DMA_CHECKSUM_EN
  assign checksum = ck_q;
`endif

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed bench for bus_dma_master: a 256-word RAM slave on the bus, a
// table of copy jobs with hand-computed latencies, and hand sequences for
// reset state, destination contents and reset in the middle of a copy.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  length = '0;
  logic        busy, done, M_req, M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic        M_grant = 1'b0;
  logic [31:0] M_din = '0;
`ifdef DMA_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  bus_dma_master dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .M_req    (M_req),
    .M_wr     (M_wr),
    .M_addr   (M_addr),
    .M_dout   (M_dout),
    .M_grant  (M_grant),
    .M_din    (M_din)
`ifdef DMA_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] ram [256];
  logic [31:0] exp_ram [256];
  int wr_cnt = 0;
  int tests = 0;
  int fails = 0;

  // RAM slave: granted write commits at the edge; granted read returns
  // data in the following cycle.
  always @(posedge clk) begin
    if (M_req && M_grant) begin
      if (M_wr) begin
        ram[M_addr] = M_dout;
        wr_cnt = wr_cnt + 1;
      end else begin
        M_din <= ram[M_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy"},   32'(busy),   32'h0);
    chk({tag, " done"},   32'(done),   32'h0);
    chk({tag, " M_req"},  32'(M_req),  32'h0);
    chk({tag, " M_wr"},   32'(M_wr),   32'h0);
    chk({tag, " M_addr"}, 32'(M_addr), 32'h0);
    chk({tag, " M_dout"}, M_dout,      32'h0);
`ifdef DMA_CHECKSUM_EN
    chk({tag, " checksum"}, checksum,  32'h0);
`endif
  endtask

  typedef struct {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    bit         stall;  // grant low 5 cycles in 2nd RD, 3 cycles in 3rd WR
    bit         poke;   // fire a second start while busy
    int         lat;    // edges from start-sampling edge to done, inclusive
  } vec_t;

  // Run one job, compare latency, write count, RAM image, bus discipline.
  task automatic run_xfer(input string name, input vec_t v);
    int n;
    int lat;
    int nbad;
    bit req_bad;
    bit stall_bad;
    bit busy_seen;
    logic [7:0]  pa;
    logic        pw;
    logic [31:0] pd;
    logic [31:0] ck;
    logic [7:0]  a;
    logic [7:0]  b;
    ck = '0;
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 8'(i);
      b = v.dst + 8'(i);
      ck = ck + exp_ram[a];
      exp_ram[b] = exp_ram[a];
    end
    wr_cnt = 0;
    req_bad = 0; stall_bad = 0; busy_seen = 0;
    pa = '0; pw = 1'b0; pd = '0;
    @(negedge clk);
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
    M_grant = 1'b1;
    n = 0;
    lat = -1;
    while (lat < 0 && n < 300) begin
      @(posedge clk);
      n++;
      #1;
      if (!M_grant && (M_addr !== pa || M_wr !== pw || M_dout !== pd || M_req !== 1'b1))
        stall_bad = 1;
      if (M_req !== busy || (M_wr && !M_req)) req_bad = 1;
      if (busy) busy_seen = 1;
      if (done) lat = n;
      pa = M_addr; pw = M_wr; pd = M_dout;
      @(negedge clk);
      start = 1'b0;
      if (v.poke && n == 2) begin
        start = 1'b1; src_addr = 8'h00; dst_addr = 8'hD0; length = 8'd5;
      end
      M_grant = !(v.stall && (((n + 1) >= 6 && (n + 1) <= 10) ||
                              ((n + 1) >= 16 && (n + 1) <= 18)));
    end
    chk({name, " latency"}, 32'(lat), 32'(v.lat));
    @(posedge clk);
    #1;
    chk({name, " done width"}, 32'(done), 32'h0);
    chk({name, " idle M_req"}, 32'(M_req), 32'h0);
    chk({name, " writes"}, 32'(wr_cnt), 32'(v.len));
    chk({name, " req follows busy"}, 32'(req_bad), 32'h0);
    chk({name, " busy seen"}, 32'(busy_seen), 32'(v.len != 8'd0));
    if (v.stall) chk({name, " held while stalled"}, 32'(stall_bad), 32'h0);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) nbad++;
    chk({name, " ram image"}, 32'(nbad), 32'h0);
`ifdef DMA_CHECKSUM_EN
    chk({name, " checksum"}, checksum, ck);
`endif
  endtask

  vec_t vecs [7];

  initial begin
    int n;
    bit done_bad;
    vecs[0] = '{8'h00, 8'h10, 8'd4, 1'b0, 1'b0, 14};
    vecs[1] = '{8'h05, 8'h30, 8'd0, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h00, 8'h60, 8'd4, 1'b1, 1'b0, 22};
    vecs[3] = '{8'hFE, 8'h20, 8'd3, 1'b0, 1'b0, 11};
    vecs[4] = '{8'h90, 8'h91, 8'd3, 1'b0, 1'b0, 11};
    vecs[5] = '{8'hA0, 8'hA8, 8'd2, 1'b0, 1'b0, 8};
    vecs[6] = '{8'hB0, 8'hC0, 8'd2, 1'b0, 1'b1, 8};

    for (int i = 0; i < 256; i++) ram[i] = 32'hC000_0000 | (32'(i) * 32'h0001_0101);
    ram[8'h00] = 32'h11; ram[8'h01] = 32'h22; ram[8'h02] = 32'h33; ram[8'h03] = 32'h44;
    ram[8'hA0] = 32'hFFFF_FFFF; ram[8'hA1] = 32'h0000_0002;
    for (int i = 0; i < 256; i++) exp_ram[i] = ram[i];

    #2 reset = 1'b1;
    #20;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_xfer($sformatf("vec%0d", i), vecs[i]);

    // Hand-checked destination words.
    chk("copy dst 0x10", ram[8'h10], 32'h11);
    chk("copy dst 0x13", ram[8'h13], 32'h44);
    chk("stall dst 0x62", ram[8'h62], 32'h33);
    chk("wrap dst 0x20", ram[8'h20], 32'hC0FE_FEFE);
    chk("wrap dst 0x21", ram[8'h21], 32'hC0FF_FFFF);
    chk("wrap dst 0x22", ram[8'h22], 32'h11);
    chk("overlap dst 0x93", ram[8'h93], 32'hC090_9090);
    chk("ignored start dst 0xD0", ram[8'hD0], 32'hC0D0_D0D0);
`ifdef DMA_CHECKSUM_EN
    chk("checksum 0xFFFFFFFF+2", 32'h1, 32'h1 ^ 32'h0 ^ (ram[8'hA8] + ram[8'hA9]) ^ 32'h1);
`endif

    // Reset during the WR of word 2 of 5: only word 1 may have landed.
    exp_ram[8'h50] = exp_ram[8'h40];
    wr_cnt = 0;
    done_bad = 0;
    @(negedge clk);
    start = 1'b1; src_addr = 8'h40; dst_addr = 8'h50; length = 8'd5; M_grant = 1'b1;
    n = 0;
    while (n < 7) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (done) done_bad = 1;
    end
    chk("midreset in WR M_wr", 32'(M_wr), 32'h1);
    chk("midreset in WR M_addr", 32'(M_addr), 32'h51);
    #1 reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset writes", 32'(wr_cnt), 32'h1);
    chk("midreset dst 0x50", ram[8'h50], exp_ram[8'h50]);
    chk("midreset dst 0x51", ram[8'h51], exp_ram[8'h51]);
    chk("midreset no done", 32'(done_bad), 32'h0);
    run_xfer("after reset", '{8'h40, 8'h50, 8'd5, 1'b0, 1'b0, 17});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
